control_loop_sequencer: RTL
===========================

Name: control_loop_sequencer

Overview:
- Initiator side of the control-loop handshake: owns one control step per simulation time-step.
- On a step request it latches reference/measurement pairs and drives them stable into the control loop's input_1..input_4.
- It pulses the loop's sta, pulses done_read_x once the loop's input stage has consumed the operands, then waits for done_sig and captures output_1/output_2 into held control registers.
- Sits between the network-solution/measurement stage and the PI control loop; also supervises timeouts and overruns.

Parameters:
- DW, 32, operand width (IEEE-754 single).
- HOLD_CYC, 8, cycles after loop_sta before done_read_x; operands are frozen through this window. Must be >= 1 and < TIMEOUT.
- TIMEOUT, 64, maximum cycles from loop_sta to loop_done before abort. Must be > HOLD_CYC.
- CW, 16, step counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rst_user  in  1  synchronous user clear; same effect as rst.
- step_req  in  1  one-cycle request to run a control step.
- ref_1, meas_1, ref_2, meas_2  in  DW each  operands; error_k = ref_k - meas_k.
- loop_done  in  1  done_sig from the control loop.
- loop_out_1, loop_out_2  in  DW each  output_1/output_2 from the control loop.
- loop_in_1, loop_in_2, loop_in_3, loop_in_4  out  DW each  registered ref_1, meas_1, ref_2, meas_2 to input_1..input_4.
- loop_sta  out  1  one-cycle start pulse to the loop.
- done_read_x  out  1  one-cycle "operands consumed" pulse to the loop.
- ctrl_1, ctrl_2  out  DW each  held control outputs.
- ctrl_valid  out  1  one-cycle pulse when ctrl_1/ctrl_2 update.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag: loop_done never arrived.
- overrun_err  out  1  sticky flag: step_req received while busy.
- step_count  out  CW  number of completed steps.

Behaviour:
- Reset (rst or rst_user), both synchronous: every output goes to 0, state goes to IDLE, counters clear. A reset mid-step aborts the step with no ctrl_valid.
- States: IDLE, ISSUE, HOLD, WAIT.
- IDLE:
  - On step_req: latch ref_1→loop_in_1, meas_1→loop_in_2, ref_2→loop_in_3, meas_2→loop_in_4; go to ISSUE.
  - loop_in_* change only on this edge.
- ISSUE (1 cycle): loop_sta=1; cycle counter cnt=0; go to HOLD.
- HOLD:
  - cnt increments each cycle.
  - When cnt reaches HOLD_CYC-1, done_read_x=1 for that cycle and the next state is WAIT.
  - If loop_done=1 while in HOLD: capture immediately (see WAIT). In that same cycle done_read_x=1 if it has not already pulsed. Go to IDLE.
- WAIT:
  - cnt continues counting.
  - On loop_done=1: ctrl_1<=loop_out_1 and ctrl_2<=loop_out_2 on that edge; ctrl_valid=1 the next cycle for exactly 1 cycle; step_count increments; go to IDLE.
  - If cnt reaches TIMEOUT-1 with loop_done=0: set timeout_err, leave ctrl_* unchanged, go to IDLE, step_count not incremented.
  - loop_done and timeout in the same cycle: completion wins and timeout_err is not set.
- Timing with step_req in cycle 0:
  - loop_in_* valid and loop_sta high in cycle 1.
  - done_read_x in cycle HOLD_CYC.
  - If loop_done arrives in cycle 1+L, ctrl_valid is high in cycle 2+L. With the 28-cycle loop, ctrl_valid is in cycle 30.
- step_req while busy: ignored and overrun_err set (sticky). A step_req in the same cycle the FSM returns to IDLE counts as busy.
- loop_done in IDLE or ISSUE: ignored; no flag.
- step_count wraps from 2^CW-1 to 0.
- ctrl_1/ctrl_2 hold their last captured value indefinitely and are never transiently corrupted.
- No arithmetic in this block; operands pass bit-exact.

Test Plan:
- Reset, then step_req with ref_1=0x40400000, meas_1=0x3F800000, ref_2=0x41200000, meas_2=0x40A00000; loop model returns done 28 cycles after sta with out_1=0x40000000, out_2=0x40A00000.
  - Required: loop_sta in cycle 1; loop_in_* equal the operands from cycle 1 to completion.
  - Required: done_read_x in cycle 8; ctrl_valid in cycle 30 with ctrl_1=0x40000000, ctrl_2=0x40A00000; step_count=1.
- Loop model never asserts done.
  - Required: timeout_err=1 at cnt=63; busy drops; ctrl_* unchanged; step_count unchanged; a following step still works.
- loop_done exactly at cnt=TIMEOUT-1.
  - Required: capture succeeds and timeout_err stays 0.
- loop_done at cnt=3 (inside HOLD).
  - Required: done_read_x and capture in that cycle; ctrl_valid the next cycle; return to IDLE.
- step_req pulses at cycles 0, 10 and 30 (30 coincides with ctrl_valid).
  - Required: one step runs; overrun_err=1; step_count=1 after completion.
- rst_user asserted in WAIT, and separately with step_count=0xFFFF.
  - Required: mid-step reset gives all outputs 0 and no ctrl_valid.
  - Required: without reset, one more completed step wraps step_count from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/control_loop_sequencer_if.sv
// Handshake bundle between the control-loop sequencer, the measurement stage
// feeding it, and the PI control loop it drives.
interface control_loop_sequencer_if #(
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          step_req;
    logic [DW-1:0] ref_1;
    logic [DW-1:0] meas_1;
    logic [DW-1:0] ref_2;
    logic [DW-1:0] meas_2;
    logic          loop_done;
    logic [DW-1:0] loop_out_1;
    logic [DW-1:0] loop_out_2;
    logic [DW-1:0] loop_in_1;
    logic [DW-1:0] loop_in_2;
    logic [DW-1:0] loop_in_3;
    logic [DW-1:0] loop_in_4;
    logic          loop_sta;
    logic          done_read_x;
    logic [DW-1:0] ctrl_1;
    logic [DW-1:0] ctrl_2;
    logic          ctrl_valid;
    logic          busy;
    logic          timeout_err;
    logic          overrun_err;
    logic [CW-1:0] step_count;

    modport master (
        input  step_req, ref_1, meas_1, ref_2, meas_2,
               loop_done, loop_out_1, loop_out_2,
        output loop_in_1, loop_in_2, loop_in_3, loop_in_4,
               loop_sta, done_read_x, ctrl_1, ctrl_2, ctrl_valid,
               busy, timeout_err, overrun_err, step_count
    );

    modport slave (
        output step_req, ref_1, meas_1, ref_2, meas_2,
               loop_done, loop_out_1, loop_out_2,
        input  loop_in_1, loop_in_2, loop_in_3, loop_in_4,
               loop_sta, done_read_x, ctrl_1, ctrl_2, ctrl_valid,
               busy, timeout_err, overrun_err, step_count
    );
endinterface

// File: rtl/control_loop_sequencer.sv
// Initiator for one PI control-loop step: freezes operands, pulses start and
// operand-consumed, captures the loop outputs and supervises timeout/overrun.
module control_loop_sequencer #(
    parameter int DW       = 32,
    parameter int HOLD_CYC = 8,
    parameter int TIMEOUT  = 64,
    parameter int CW       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rst_user,
    control_loop_sequencer_if.master  bus
);
    localparam int CNTW = $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CW-1:0]   STEP_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic            loop_sta_q;
    logic [DW-1:0]   ctrl_1_q;
    logic [DW-1:0]   ctrl_2_q;
    logic            ctrl_valid_q;
    logic            timeout_q;
    logic            overrun_q;
    logic [CW-1:0]   step_count_q;
    logic            ret_q;          // first cycle back in IDLE still counts as busy

    logic            clr;
    logic            latch_en;
    logic            in_loop;
    logic [DW-1:0]   opnd [4];
    logic [DW-1:0]   loop_in_w [4];

    assign clr      = rst | rst_user;
    assign latch_en = (state_q == IDLE) && bus.step_req && !ret_q;
    assign in_loop  = (state_q == HOLD) || (state_q == WAIT);

    assign opnd[0] = bus.ref_1;
    assign opnd[1] = bus.meas_1;
    assign opnd[2] = bus.ref_2;
    assign opnd[3] = bus.meas_2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_opnd
            logic [DW-1:0] opnd_q;
            always_ff @(posedge clk) begin
                if (clr) begin
                    opnd_q <= '0;
                end else if (latch_en) begin
                    opnd_q <= opnd[gi];
                end
            end
            assign loop_in_w[gi] = opnd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            loop_sta_q   <= 1'b0;
            ctrl_1_q     <= '0;
            ctrl_2_q     <= '0;
            ctrl_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
            step_count_q <= '0;
            ret_q        <= 1'b0;
        end else begin
            loop_sta_q   <= 1'b0;
            ctrl_valid_q <= 1'b0;
            ret_q        <= 1'b0;
            if (bus.step_req && ((state_q != IDLE) || ret_q)) begin
                overrun_q <= 1'b1;
            end
            // Completion takes priority over the timeout check in the same cycle.
            if (in_loop && bus.loop_done) begin
                ctrl_1_q     <= bus.loop_out_1;
                ctrl_2_q     <= bus.loop_out_2;
                ctrl_valid_q <= 1'b1;
                step_count_q <= step_count_q + STEP_ONE;
                state_q      <= IDLE;
                ret_q        <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (latch_en) begin
                            state_q    <= ISSUE;
                            loop_sta_q <= 1'b1;
                            cnt_q      <= '0;
                        end
                    end
                    ISSUE: begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        state_q <= (cnt_q == HOLD_LAST) ? WAIT : HOLD;
                    end
                    HOLD: begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == HOLD_LAST) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (cnt_q == TO_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                            ret_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // The early-completion case must acknowledge the operands in the same
    // cycle as loop_done, so this strobe is decoded rather than registered.
    assign bus.done_read_x = ((state_q == ISSUE) && (cnt_q == HOLD_LAST)) ||
                             ((state_q == HOLD) && ((cnt_q == HOLD_LAST) || bus.loop_done));

    assign bus.loop_in_1   = loop_in_w[0];
    assign bus.loop_in_2   = loop_in_w[1];
    assign bus.loop_in_3   = loop_in_w[2];
    assign bus.loop_in_4   = loop_in_w[3];
    assign bus.loop_sta    = loop_sta_q;
    assign bus.ctrl_1      = ctrl_1_q;
    assign bus.ctrl_2      = ctrl_2_q;
    assign bus.ctrl_valid  = ctrl_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = timeout_q;
    assign bus.overrun_err = overrun_q;
    assign bus.step_count  = step_count_q;
endmodule
